// File: rtl/force_release_pkg.sv
// Shared encodings for the debug-override stage: command opcodes and
// the per-channel override state.
package force_release_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP         = 2'b00,
    OP_FORCE       = 2'b01,
    OP_RELEASE     = 2'b10,
    OP_RELEASE_ALL = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_FORCED = 2'd1,
    ST_HELD   = 2'd2
  } chan_state_e;

endpackage

// File: rtl/force_release_channel.sv
// One overridable channel: tracks the functional shadow value, the forced
// value and the FREE/FORCED/HELD state, and registers the consumer output.
module force_release_channel
  import force_release_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             func_valid,
  input  logic [WIDTH-1:0] func_data,
  input  logic             force_req,
  input  logic             release_req,
  input  logic [WIDTH-1:0] force_value,
  output logic [WIDTH-1:0] out_data,
  output logic             forced,
  output logic             held
);

  chan_state_e      state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] force_val_q, force_val_d;
  logic [WIDTH-1:0] out_q, out_d;

  always_comb begin
    shadow_d    = func_valid ? func_data : shadow_q;
    state_d     = state_q;
    force_val_d = force_val_q;
    case (state_q)
      ST_FREE: begin
        if (force_req) begin
          state_d     = ST_FORCED;
          force_val_d = force_value;
        end
      end
      ST_FORCED: begin
        // A functional write alone never leaves FORCED; a register-like
        // release that coincides with one skips HELD and goes straight to FREE.
        if (force_req) begin
          force_val_d = force_value;
        end else if (release_req) begin
          state_d = (MODE && !func_valid) ? ST_HELD : ST_FREE;
        end
      end
      ST_HELD: begin
        if (force_req) begin
          state_d     = ST_FORCED;
          force_val_d = force_value;
        end else if (func_valid) begin
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
    out_d = (state_d == ST_FREE) ? shadow_d : force_val_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FREE;
      shadow_q    <= '0;
      force_val_q <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      force_val_q <= force_val_d;
      out_q       <= out_d;
    end
  end

  assign out_data = out_q;
  assign forced   = (state_q == ST_FORCED);
  assign held     = (state_q == ST_HELD);

endmodule

// File: rtl/force_release_override.sv
// Debug-override stage: accepts FORCE/RELEASE commands through a two-cycle
// handshake and substitutes forced values on the registered channel outputs.
module force_release_override
  import force_release_pkg::*;
#(
  parameter int                  WIDTH        = 8,
  parameter int                  CHANNELS     = 4,
  parameter logic [CHANNELS-1:0] RELEASE_MODE = 4'b0101
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] func_data,
  input  logic [CHANNELS-1:0]       func_valid,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OP_W-1:0]           cmd_op,
  input  logic [3:0]                cmd_chan,
  input  logic [WIDTH-1:0]          cmd_value,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       forced,
  output logic [CHANNELS-1:0]       held,
  output logic                      cmd_err
);

  localparam logic [4:0] CHAN_LIM = 5'(CHANNELS);

  logic    busy_q;
  logic    cmd_err_q, cmd_err_d;
  logic    accept;
  logic    chan_ok;
  cmd_op_e op;

  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = !busy_q;
  assign accept    = cmd_valid && !busy_q;
  assign chan_ok   = ({1'b0, cmd_chan} < CHAN_LIM);

  // Out-of-range targets are consumed like any command but touch no channel.
  always_comb begin
    cmd_err_d = 1'b0;
    if (accept && ((op == OP_FORCE) || (op == OP_RELEASE)) && !chan_ok) begin
      cmd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      busy_q    <= accept;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign cmd_err = cmd_err_q;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic hit;
      logic force_req;
      logic release_req;

      assign hit         = accept && chan_ok && (cmd_chan == 4'(gi));
      assign force_req   = hit && (op == OP_FORCE);
      assign release_req = (hit && (op == OP_RELEASE)) ||
                           (accept && (op == OP_RELEASE_ALL));

      force_release_channel #(
        .WIDTH (WIDTH),
        .MODE  (RELEASE_MODE[gi])
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .func_valid  (func_valid[gi]),
        .func_data   (func_data[gi*WIDTH +: WIDTH]),
        .force_req   (force_req),
        .release_req (release_req),
        .force_value (cmd_value),
        .out_data    (out_data[gi*WIDTH +: WIDTH]),
        .forced      (forced[gi]),
        .held        (held[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_force_release_override.sv
// Scoreboarded bench: the driver updates a rule-level model and queues the
// expected post-edge outputs; an independent monitor compares them.
module tb_force_release_override;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam logic [CH-1:0] MODE = 4'b0101;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*W-1:0]   func_data;
  logic [CH-1:0]     func_valid;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_chan;
  logic [W-1:0]      cmd_value;
  logic [CH*W-1:0]   out_data;
  logic [CH-1:0]     forced;
  logic [CH-1:0]     held;
  logic              cmd_err;

  force_release_override #(.WIDTH(W), .CHANNELS(CH), .RELEASE_MODE(MODE)) dut (
    .clk        (clk),
    .rst        (rst),
    .func_data  (func_data),
    .func_valid (func_valid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_chan   (cmd_chan),
    .cmd_value  (cmd_value),
    .out_data   (out_data),
    .forced     (forced),
    .held       (held),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*W-1:0] out;
    logic [CH-1:0]   frc;
    logic [CH-1:0]   hld;
    logic            err;
    logic            rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: 0 = free, 1 = forced, 2 = held
  int         m_st[CH];
  logic [7:0] m_sh[CH];
  logic [7:0] m_fv[CH];
  bit         m_busy;
  bit         m_err;

  task automatic step(input bit r, input logic [CH-1:0] fvld, input logic [CH*W-1:0] fdat,
                      input bit cv, input logic [1:0] op, input logic [3:0] ch,
                      input logic [7:0] val);
    exp_t e;
    bit   acc;
    @(negedge clk);
    rst = r; func_valid = fvld; func_data = fdat;
    cmd_valid = cv; cmd_op = op; cmd_chan = ch; cmd_value = val;
    if (r) begin
      for (int i = 0; i < CH; i++) begin m_st[i] = 0; m_sh[i] = '0; m_fv[i] = '0; end
      m_busy = 0; m_err = 0;
    end else begin
      acc   = cv && !m_busy;
      m_err = 0;
      for (int i = 0; i < CH; i++) if (fvld[i]) m_sh[i] = fdat[i*W +: W];
      if (acc) begin
        case (op)
          2'b01: if (ch < CH) begin m_st[ch] = 1; m_fv[ch] = val; end else m_err = 1;
          2'b10: if (ch < CH) begin
                   if (m_st[ch] == 1) m_st[ch] = MODE[ch] ? 2 : 0;
                 end else m_err = 1;
          2'b11: for (int i = 0; i < CH; i++) if (m_st[i] == 1) m_st[i] = MODE[i] ? 2 : 0;
          default: ;
        endcase
        $display("cmd op=%0d ch=%0d val=%02h err=%0b", op, ch, val, m_err);
      end
      for (int i = 0; i < CH; i++) if (m_st[i] == 2 && fvld[i]) m_st[i] = 0;
      m_busy = acc;
    end
    for (int i = 0; i < CH; i++) begin
      e.out[i*W +: W] = (m_st[i] == 0) ? m_sh[i] : m_fv[i];
      e.frc[i]        = (m_st[i] == 1);
      e.hld[i]        = (m_st[i] == 2);
    end
    e.err = m_err;
    e.rdy = !m_busy;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, '0, '0, 0, 2'b00, 4'd0, 8'h00);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] ch, input logic [7:0] val);
    step(0, '0, '0, 1, op, ch, val);
    idle();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents registered outputs to compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data",  out_data,         e.out);
        check("forced",    32'(forced),      32'(e.frc));
        check("held",      32'(held),        32'(e.hld));
        check("cmd_err",   32'(cmd_err),     32'(e.err));
        check("cmd_ready", 32'(cmd_ready),   32'(e.rdy));
      end
    end
  end

  initial begin
    bit         cv;
    logic [1:0] op;
    logic [3:0] ch;
    logic [7:0] val;
    int         wait_cycles;

    rst = 1; func_valid = '0; func_data = '0;
    cmd_valid = 0; cmd_op = '0; cmd_chan = '0; cmd_value = '0;
    step(1, '0, '0, 0, 2'b00, 4'd0, 8'h00);
    step(1, '0, '0, 0, 2'b00, 4'd0, 8'h00);

    // Pass-through after reset
    step(0, 4'b0010, 32'h0000_3C00, 0, 2'b00, 4'd0, 8'h00);
    idle();
    // Register-like force/release on ch0
    cmd(2'b01, 4'd0, 8'hA5);
    step(0, 4'b0001, 32'h0000_0011, 0, 2'b00, 4'd0, 8'h00);
    cmd(2'b10, 4'd0, 8'h00);
    step(0, 4'b0001, 32'h0000_0022, 0, 2'b00, 4'd0, 8'h00);
    idle();
    // Net-like release on ch1
    cmd(2'b01, 4'd1, 8'h7E);
    cmd(2'b10, 4'd1, 8'h00);
    // RELEASE_ALL with mixed modes
    cmd(2'b01, 4'd2, 8'h01);
    cmd(2'b01, 4'd3, 8'h02);
    cmd(2'b11, 4'd0, 8'h00);
    // Back-to-back valid, then out-of-range target
    for (int k = 0; k < 4; k++) step(0, '0, '0, 1, 2'b01, 4'd1, 8'h55);
    idle();
    cmd(2'b01, 4'd5, 8'h99);
    idle();
    // Reset in the middle of a force
    cmd(2'b01, 4'd0, 8'hFF);
    step(1, '0, '0, 0, 2'b00, 4'd0, 8'h00);
    step(0, 4'b0001, 32'h0000_0010, 0, 2'b00, 4'd0, 8'h00);
    idle();

    // Randomized traffic; command fields held while the model is busy
    cv = 0; op = '0; ch = '0; val = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [CH-1:0]   fv;
      logic [CH*W-1:0] fd;
      for (int i = 0; i < CH; i++) fv[i] = ($urandom_range(0, 3) == 0);
      fd = $urandom;
      if (!m_busy) begin
        cv  = ($urandom_range(0, 1) == 1);
        op  = 2'($urandom_range(0, 3));
        ch  = 4'($urandom_range(0, 5));
        val = 8'($urandom);
      end
      step(($urandom_range(0, 199) == 0), fv, fd, cv, op, ch, val);
    end
    idle();

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/force_release_override.md
Name: force_release_override

Overview:
- Synthesizable debug-override stage between a bank of functional datapath registers and their consumers.
- A stimulus/debug controller issues FORCE and RELEASE commands per channel, and the stage substitutes forced values on its output.
- Release semantics are selectable per channel:
  - Register-like: the forced value is held after release until the next functional write.
  - Net-like: the output returns immediately to the functionally driven value.
- Consumers see only out_data; the functional source never sees the override.

Parameters:
- WIDTH, 8, data width per channel.
- CHANNELS, 4, number of overridable channels (2..16).
- RELEASE_MODE, 4'b0101, CHANNELS-bit mask; bit i=1 gives register-like release on channel i, bit i=0 gives net-like release.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- func_data  in  CHANNELS*WIDTH  functional values, channel i at [i*WIDTH +: WIDTH]
- func_valid  in  CHANNELS  per-channel functional write strobe
- cmd_valid  in  1  command request
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  2  00 NOP, 01 FORCE, 10 RELEASE, 11 RELEASE_ALL
- cmd_chan  in  4  target channel (ignored for NOP and RELEASE_ALL)
- cmd_value  in  WIDTH  value for FORCE
- out_data  out  CHANNELS*WIDTH  overridden outputs, registered
- forced  out  CHANNELS  channel i is in FORCED
- held  out  CHANNELS  channel i is in HELD
- cmd_err  out  1  one-cycle pulse when a command targets channel >= CHANNELS

Behaviour:
- Reset (sync, active-high):
  - All channels go to FREE; shadow, force_val, out_data, forced and held clear to 0.
  - cmd_err is 0, busy is 0, so cmd_ready is 1 in the first cycle after reset.
  - Reset asserted mid-force discards the force entirely.
- Shadow register:
  - On every edge with func_valid[i], shadow[i] <= func_data[i].
  - This happens regardless of channel state.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - busy sets on accept and clears on the next edge, so cmd_ready = !busy and at most one command is accepted every 2 cycles.
  - While cmd_ready is low, cmd_* inputs are ignored and must be held by the source.
- Per-channel states and transitions (evaluated at the accept edge):
  - FREE: out_data = shadow, one-cycle latency from func_valid. FORCE goes to FORCED with force_val <= cmd_value; RELEASE is a no-op.
  - FORCED: out_data = force_val. FORCE updates force_val. RELEASE goes to HELD if RELEASE_MODE[i], else to FREE.
  - HELD: out_data = force_val. func_valid[i] goes to FREE and out_data takes func_data[i] that edge. FORCE goes to FORCED; RELEASE is a no-op.
- Simultaneous events:
  - FORCE and func_valid on the same channel, same edge: the force wins on out_data; shadow still captures.
  - RELEASE (register-like) and func_valid on the same edge: the channel goes directly to FREE with func_data.
  - RELEASE (net-like): out_data equals the post-edge shadow, including any same-edge func_valid.
  - A functional write arriving while FORCED never exits FORCED.
- RELEASE_ALL: applies RELEASE to every FORCED channel in the same edge, each per its own mode.
- cmd_err:
  - Pulses for one cycle after an accepted FORCE or RELEASE with cmd_chan >= CHANNELS.
  - No state changes; the command is still consumed and busy still sets.
- NOP: consumed with no effect.
- Status outputs:
  - out_data, forced and held are registered and consistent with each other every cycle.
  - There is no combinational path from any input to any output except cmd_ready from busy.

Decomposition:
- Shared package force_release_pkg holds:
  - the op encodings OP_NOP, OP_FORCE, OP_RELEASE, OP_RELEASE_ALL;
  - the channel state enum ST_FREE, ST_FORCED, ST_HELD;
  - the cmd_op width constant.
- One sub-module, force_release_channel (parameter WIDTH and a 1-bit MODE), generated CHANNELS times. It holds the state, shadow and force_val for one channel.
- The top level keeps the handshake, busy, command decode and cmd_err.

Test Plan:
1. Reset, then func_valid[1] with 8'h3C -> out_data ch1 = 8'h3C one cycle later; forced = 0, held = 0, cmd_ready = 1.
2. FORCE ch0 = 8'hA5, then func_valid[0] with 8'h11 -> ch0 stays 8'hA5 and forced[0] = 1. RELEASE ch0 (register-like) -> held[0] = 1, still 8'hA5. Next func_valid[0] with 8'h22 -> 8'h22, held[0] = 0.
3. FORCE ch1 = 8'h7E with shadow 8'h3C, then RELEASE ch1 (net-like) -> out_data ch1 = 8'h3C the cycle after accept; forced[1] = 0, held[1] = 0.
4. FORCE ch2 = 8'h01 and FORCE ch3 = 8'h02, then RELEASE_ALL -> held = 4'b0100, forced = 0, ch3 returns to its shadow value.
5. Back-to-back cmd_valid for 4 cycles -> exactly 2 commands accepted and cmd_ready alternates 1,0,1,0. FORCE with cmd_chan = 5 -> cmd_err pulses for 1 cycle and state is unchanged.
6. FORCE ch0 = 8'hFF, then assert rst for 1 cycle -> out_data = 0, forced = 0, and a subsequent func_valid[0] with 8'h10 passes through.
